// File: rtl/dispatch_pkg.sv
// Shared lane constants and rotate/priority helpers for the 1:4 dispatcher.
// Pure combinational helpers, no state.
// No flow control here; used by the dispatcher top.
package dispatch_pkg;

    localparam int NLANES = 4;
    localparam int PTRW   = 2;

    // One-hot lane identifiers, same encoding as the 4:1 merging arbiter.
    localparam logic [NLANES-1:0] LANE0 = 4'b0001;
    localparam logic [NLANES-1:0] LANE1 = 4'b0010;
    localparam logic [NLANES-1:0] LANE2 = 4'b0100;
    localparam logic [NLANES-1:0] LANE3 = 4'b1000;

    // Rotate right by s: bit i of the result is lane (i+s) mod 4.
    function automatic logic [NLANES-1:0] rotr4(input logic [NLANES-1:0] v,
                                               input logic [PTRW-1:0]   s);
        logic [NLANES-1:0] r;
        logic [PTRW-1:0]   j;
        r = '0;
        for (int i = 0; i < NLANES; i++) begin
            j    = s + PTRW'(i);
            r[i] = v[j];
        end
        return r;
    endfunction

    // Inverse of rotr4: result bit (i+s) mod 4 is v[i].
    function automatic logic [NLANES-1:0] rotl4(input logic [NLANES-1:0] v,
                                               input logic [PTRW-1:0]   s);
        logic [NLANES-1:0] r;
        logic [PTRW-1:0]   j;
        r = '0;
        for (int i = 0; i < NLANES; i++) begin
            j    = s + PTRW'(i);
            r[j] = v[i];
        end
        return r;
    endfunction

    // Lowest set bit as a one-hot vector, zero if none.
    function automatic logic [NLANES-1:0] first_one(input logic [NLANES-1:0] v);
        logic [NLANES-1:0] r;
        r = '0;
        if (v[0])      r = LANE0;
        else if (v[1]) r = LANE1;
        else if (v[2]) r = LANE2;
        else if (v[3]) r = LANE3;
        return r;
    endfunction

    // One-hot to lane index.
    function automatic logic [PTRW-1:0] onehot_idx(input logic [NLANES-1:0] v);
        logic [PTRW-1:0] r;
        r = '0;
        case (v)
            LANE1:   r = 2'd1;
            LANE2:   r = 2'd2;
            LANE3:   r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dispatch_lane.sv
// One-entry register slice for a single downstream lane.
// Latency 1 cycle from load to valid_q.
// Free when empty or draining this cycle, so drain and refill overlap with no bubble.
module dispatch_lane #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] data,
    input  logic          ready_in,
    output logic          valid_q,
    output logic [DW-1:0] data_q,
    output logic          free
);

    logic          valid_d;
    logic [DW-1:0] data_d;

    assign free = ~valid_q | ready_in;

    // Next state: a new word wins over a drain; a stalled word holds.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data;
        end else if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end
    end

    // Slice registers; data is kept after a drain, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/dispatcher4.sv
// 1:4 round-robin dispatcher feeding four independent one-entry lane slices.
// Latency 1 cycle from upstream handshake to the granted lane's valid_out.
// ready_out is high whenever any lane is free (not during reset); independent of valid_in.
module dispatcher4
    import dispatch_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [DW-1:0]        data_in,
    input  logic [NLANES-1:0]    ready_in,
    output logic [NLANES-1:0]    valid_out,
    output logic [NLANES*DW-1:0] data_out
);

    logic [PTRW-1:0]   ptr_q, ptr_d;
    logic [NLANES-1:0] free;
    logic [NLANES-1:0] grant;
    logic [NLANES-1:0] load;
    logic              hs;

    // Rotate so ptr sits at bit 0, take the first free lane, rotate back.
    always_comb begin
        grant = rotl4(first_one(rotr4(free, ptr_q)), ptr_q);
    end

    assign ready_out = (|free) & ~rst;
    assign hs        = valid_in & ready_out;
    assign load      = grant & {NLANES{hs}};

    // Pointer moves one past the granted lane; holds without a handshake.
    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = onehot_idx(grant) + 2'd1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    for (genvar k = 0; k < NLANES; k++) begin : g_lane
        dispatch_lane #(.DW(DW)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .load     (load[k]),
            .data     (data_in),
            .ready_in (ready_in[k]),
            .valid_q  (valid_out[k]),
            .data_q   (data_out[k*DW +: DW]),
            .free     (free[k])
        );
    end

endmodule
